// File: rtl/io_pkg.sv
// io_pkg: shared address-decode constants for the memory-mapped I/O region
// of the RISC-V SoC, plus the debounce default and a decode helper.
// Each I/O register is selected by one address bit (one-hot decode).
// Optional feature macro used by importers: IO_INPUT_IRQ_EN.
package io_pkg;

   // One-hot address bits. IO_BASE_bit marks the whole I/O region.
   localparam int IO_BASE_bit  = 8;
   localparam int IO_LEDS_bit  = 2;   // LED output register (0x104)
   localparam int IO_HEX_bit   = 3;   // HEX display register (0x108)
   localparam int IO_SW_bit    = 4;   // switch STATE register (0x110)
   localparam int IO_EDGE_bit  = 5;   // sticky EDGE register (0x120)
   localparam int IO_IRQEN_bit = 6;   // interrupt enable register (0x140)

   // 10 ms at a 50 MHz CPU clock.
   localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

   // True when the address falls in the I/O region and selects the given
   // register bit. Used for store strobes; reads apply their own priority.
   function automatic logic io_hit(input logic [31:0] a, input int sel_bit);
      return a[IO_BASE_bit] & a[sel_bit];
   endfunction

endpackage

// File: rtl/debounce.sv
// debounce: one switch bit. A 2-FF synchronizer brings the raw level into
// the clk domain; a counter then requires the new level to persist for
// DEBOUNCE_CYCLES consecutive cycles before 'stable' follows it.
// 'change' is high for exactly the cycle in which 'stable' is about to
// flip, so a register sampling it updates on the same edge as 'stable'.
module debounce
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic sw,
   output logic stable,
   output logic change
);

   localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_meta;
   logic             synced;
   logic [CNT_W-1:0] cnt;
   logic             differ;

   // Two-stage synchronizer for the asynchronous switch level.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge value of its neighbours (the second stage
   // really sees the first stage's old value, giving two distinct flops).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         synced    <= 1'b0;
      end else begin
         sync_meta <= sw;
         synced    <= sync_meta;
      end
   end

   assign differ = synced ^ stable;
   // The counter has already seen DEBOUNCE_CYCLES-1 differing cycles and
   // this is the DEBOUNCE_CYCLES-th: accept on this edge.
   assign change = differ && (cnt == CNT_LAST);

   // Hold-time counter: runs while the synced level differs, clears on
   // agreement (glitch discarded) or on acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (change) begin
         stable <= synced;
         cnt    <= '0;
      end else if (differ) begin
         cnt    <= cnt + CNT_W'(1);
      end else begin
         cnt    <= '0;
      end
   end

endmodule

// File: rtl/io_input_port.sv
// io_input_port: CPU-readable switch peripheral. Debounced switch levels
// (STATE, 0x110), a sticky write-1-to-clear change register (EDGE, 0x120)
// and, when IO_INPUT_IRQ_EN is defined, an interrupt enable register
// (IRQEN, 0x140) driving a registered level interrupt. Without the macro
// IRQEN reads 0, writes to it are dropped and irq is tied low.
// rdata is combinational and is muxed into the CPU readdata by the top
// level whenever addr[8] is set.
module io_input_port
   import io_pkg::*;
#(
   parameter int N_INPUTS        = 10,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_INPUTS-1:0] SW,
   input  logic [31:0]         addr,
   input  logic [31:0]         writedata,
   input  logic                memwrite,
   output logic [31:0]         rdata,
   output logic                irq
);

   // LED/HEX bits are decoded by the output registers next door.
   localparam int unused_out_bits = IO_LEDS_bit + IO_HEX_bit;

   logic [N_INPUTS-1:0] stable;
   logic [N_INPUTS-1:0] change;
   logic [N_INPUTS-1:0] edges;
   logic [N_INPUTS-1:0] edge_clr;
   logic [N_INPUTS-1:0] irqen;

   logic is_io;
   logic sel_state;
   logic sel_edge;
   logic sel_irqen;
   logic wr_edge;

   // Only part of the address and store data is decoded here.
   logic unused_in;
   assign unused_in = ^{addr, writedata};

   assign is_io     = addr[IO_BASE_bit];
   assign sel_state = addr[IO_SW_bit];
   assign sel_edge  = addr[IO_EDGE_bit];
   assign sel_irqen = addr[IO_IRQEN_bit];
   assign wr_edge   = memwrite & io_hit(addr, IO_EDGE_bit);

   // One synchronizer + debouncer per switch.
   for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_db
      debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk    (clk),
         .reset  (reset),
         .sw     (SW[gi]),
         .stable (stable[gi]),
         .change (change[gi])
      );
   end

   // Write-1-to-clear mask; zero unless EDGE is being stored to.
   // NOTE: every signal assigned in an always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      edge_clr = '0;
      if (wr_edge) edge_clr = writedata[N_INPUTS-1:0];
   end

   // Sticky change capture; a new change beats a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) edges <= '0;
      else       edges <= (edges & ~edge_clr) | change;
   end

`ifdef IO_INPUT_IRQ_EN
   logic wr_irqen;
   assign wr_irqen = memwrite & io_hit(addr, IO_IRQEN_bit);

   // Interrupt enable register, plain store.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         irqen <= '0;
      else if (wr_irqen) irqen <= writedata[N_INPUTS-1:0];
   end

   // Registered level interrupt: any enabled sticky edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) irq <= 1'b0;
      else       irq <= |(edges & irqen);
   end
`else
   assign irqen = '0;
   assign irq   = 1'b0;
`endif

   // Read mux with STATE > EDGE > IRQEN priority; zero outside the region.
   always_comb begin
      rdata = '0;
      if (is_io) begin
         if (sel_state)      rdata = 32'(stable);
         else if (sel_edge)  rdata = 32'(edges);
         else if (sel_irqen) rdata = 32'(irqen);
      end
   end

endmodule

// File: tb/tb_io_input_port.sv
// tb_io_input_port: drives io_input_port with DEBOUNCE_CYCLES=4 and
// N_INPUTS=10. Each read pushes its expected value into a scoreboard queue
// and the value is popped and compared once rdata/irq has settled.
// Expectations for IRQEN/irq follow IO_INPUT_IRQ_EN.
module tb_io_input_port;

   localparam int N  = 10;
   localparam int DB = 4;

`ifdef IO_INPUT_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  SW;
   logic [31:0]   addr;
   logic [31:0]   writedata;
   logic          memwrite;
   logic [31:0]   rdata;
   logic          irq;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   io_input_port #(
      .N_INPUTS        (N),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .SW        (SW),
      .addr      (addr),
      .writedata (writedata),
      .memwrite  (memwrite),
      .rdata     (rdata),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
      exp_t e;
      sb_q.push_back('{tag, exp});
      addr = a;
      #1;
      e = sb_q.pop_front();
      check(e.tag, rdata, e.exp);
   endtask

   task automatic expect_irq(input string tag, input logic exp);
      exp_t e;
      sb_q.push_back('{tag, 32'(exp)});
      #1;
      e = sb_q.pop_front();
      check(e.tag, 32'(irq), e.exp);
   endtask

   // Store occupies exactly one rising edge.
   task automatic store(input logic [31:0] a, input logic [31:0] d);
      addr      = a;
      writedata = d;
      memwrite  = 1'b1;
      tick(1);
      memwrite  = 1'b0;
      writedata = '0;
   endtask

   initial begin
      reset     = 1'b1;
      SW        = '0;
      addr      = '0;
      writedata = '0;
      memwrite  = 1'b0;
      tick(3);
      reset = 1'b0;

      // Reset state
      expect_read("rst_state", 32'h110, 32'h0);
      expect_read("rst_edge",  32'h120, 32'h0);
      expect_read("rst_irqen", 32'h140, 32'h0);
      expect_irq ("rst_irq",   1'b0);

      // SW[3] rises: accepted exactly 6 edges later
      SW[3] = 1'b1;
      tick(5);
      expect_read("sw3_state_e5", 32'h110, 32'h0);
      expect_read("sw3_edge_e5",  32'h120, 32'h0);
      tick(1);
      expect_read("sw3_state_e6", 32'h110, 32'h008);
      expect_read("sw3_edge_e6",  32'h120, 32'h008);

      // 3-cycle glitch on SW[0] is discarded
      SW[0] = 1'b1;
      tick(3);
      SW[0] = 1'b0;
      tick(8);
      expect_read("glitch_state", 32'h110, 32'h008);
      expect_read("glitch_edge",  32'h120, 32'h008);

      // Counter restarted from 0: a real SW[0] step again takes 6 edges
      SW[0] = 1'b1;
      tick(5);
      expect_read("sw0_state_e5", 32'h110, 32'h008);
      tick(1);
      expect_read("sw0_state_e6", 32'h110, 32'h009);
      expect_read("sw0_edge_e6",  32'h120, 32'h009);

      // W1C of bit 0
      store(32'h120, 32'h001);
      expect_read("w1c_bit0", 32'h120, 32'h008);

      // Decode: outside region and priority
      expect_read("rd_0x100", 32'h100, 32'h0);
      expect_read("rd_0x030", 32'h030, 32'h0);
      expect_read("rd_0x130", 32'h130, 32'h009);
      tick(1);
      expect_read("rd_0x160", 32'h160, 32'h008);

      // SW[3] falls; clear of bit 3 lands on the acceptance edge: set wins
      SW[3] = 1'b0;
      tick(5);
      store(32'h120, 32'h008);
      expect_read("setwins_state", 32'h110, 32'h001);
      expect_read("setwins_edge",  32'h120, 32'h008);
      store(32'h120, 32'h008);
      expect_read("w1c_bit3", 32'h120, 32'h0);

      // STATE is read-only
      store(32'h110, 32'h3FF);
      expect_read("state_ro", 32'h110, 32'h001);

      // IRQ path
      store(32'h140, 32'h004);
      expect_read("irqen_rd", 32'h140, IRQ_ON ? 32'h004 : 32'h0);
      SW[2] = 1'b1;
      tick(6);
      expect_read("sw2_edge", 32'h120, 32'h004);
      expect_irq ("irq_same_edge", 1'b0);
      tick(1);
      expect_irq ("irq_next", IRQ_ON);
      store(32'h120, 32'h004);
      tick(1);
      expect_irq ("irq_after_w1c", 1'b0);
      expect_read("edge_after_w1c", 32'h120, 32'h0);

      // Reset mid-debounce of SW[1]; SW[0]/SW[2] held high through reset
      SW[1] = 1'b1;
      tick(4);
      reset = 1'b1;
      expect_read("async_rst_state", 32'h110, 32'h0);
      expect_read("async_rst_irqen", 32'h140, 32'h0);
      tick(1);
      reset = 1'b0;
      tick(5);
      expect_read("post_rst_e5", 32'h110, 32'h0);
      tick(1);
      expect_read("post_rst_state", 32'h110, 32'h007);
      expect_read("post_rst_edge",  32'h120, 32'h007);
      expect_irq ("post_rst_irq", 1'b0);

      check("sb_empty", 32'(sb_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
